gelato_warp_spawner: RTL and testbench
======================================

GELATO_WARP_SPAWNER -- requirements
Module: gelato_warp_spawner

Interface
REQ-001 Parameter WARP_SIZE, default 32: threads per warp; SHALL be a power of two.
REQ-002 Parameter NUM_WARPS, default 8: maximum warps per launch.
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge triggered.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 init  interface  gelato_init_if.slave  launch request: valid, pc (addr_t), workers (integer).
REQ-006 busy  output  1  high while a launch is in progress (state not IDLE).
REQ-007 warp_valid  output  1  a warp descriptor is presented.
REQ-008 warp_ready  input  1  downstream warp scheduler accepts the descriptor.
REQ-009 warp_id  output  $clog2(NUM_WARPS)  index of the presented warp.
REQ-010 warp_pc  output  addr_t  start PC of the presented warp.
REQ-011 warp_mask  output  WARP_SIZE  active-thread mask; bit i is thread i of the warp.
REQ-012 done  output  1  one-cycle pulse when a launch finishes.
REQ-013 overflow  output  1  sticky flag: a launch was clamped, or init arrived while busy.

Function
REQ-014 States SHALL be IDLE, SPAWN and DONE.
REQ-015 IDLE: init.valid with workers > 0 SHALL latch pc and the remaining count, set warp_id to 0 and go to SPAWN; warp_valid SHALL rise on the next cycle (1-cycle latency).
REQ-016 IDLE: init.valid with workers <= 0 SHALL go directly to DONE; no warp is emitted.
REQ-017 If workers > NUM_WARPS*WARP_SIZE, the remaining count SHALL be clamped to NUM_WARPS*WARP_SIZE and overflow set.
REQ-018 SPAWN: warp_valid SHALL be 1; warp_pc SHALL equal the latched pc for every warp of the launch.
REQ-019 warp_mask SHALL be all ones if remaining >= WARP_SIZE; otherwise (1 << remaining) - 1.
REQ-020 warp_valid, warp_id, warp_pc and warp_mask SHALL stay stable while warp_valid && !warp_ready.
REQ-021 On a handshake (warp_valid && warp_ready), remaining SHALL decrease by min(remaining, WARP_SIZE) and warp_id SHALL increment by 1.
REQ-022 A handshake that brings remaining to 0 SHALL move the FSM to DONE; warp_valid SHALL be 0 the following cycle.
REQ-023 Back-to-back handshakes SHALL sustain one warp per cycle.
REQ-024 DONE: done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-025 init.valid outside IDLE SHALL be ignored (the launch in progress is unaffected) and SHALL set overflow.
REQ-026 init.valid in IDLE on the cycle after DONE SHALL be accepted normally.
REQ-027 Internal count arithmetic SHALL be at least $clog2(NUM_WARPS*WARP_SIZE)+1 bits wide; negative workers SHALL be compared as signed values.
REQ-028 overflow SHALL clear only on rst.

Reset
REQ-029 rst SHALL force state IDLE; busy, warp_valid, done and overflow to 0; warp_id, warp_pc, warp_mask and the internal count to 0.
REQ-030 rst asserted during SPAWN SHALL abort the launch; no further warps SHALL be presented.

Structure
REQ-031 WARP_SIZE, NUM_WARPS, warp_id_t, warp_mask_t and the state enum SHALL be defined in the gelato_types package; addr_t SHALL come from that same package.
REQ-032 The block SHALL be a single module; mask generation SHALL be inline combinational logic, with no sub-module.

Verification
REQ-033 workers=70, pc=0x1000, warp_ready=1 -> three warps with ids 0,1,2; masks 0xFFFFFFFF, 0xFFFFFFFF, 0x0000003F; all with pc 0x1000; done pulses one cycle after the third handshake.
REQ-034 workers=32, warp_ready held low for 5 cycles -> warp_valid and all descriptor fields are stable for 5 cycles; one warp with mask 0xFFFFFFFF is emitted when ready rises.
REQ-035 workers=0 and workers=-5 -> no warp_valid; done pulses at t+1; overflow stays 0.
REQ-036 workers=300 with NUM_WARPS=8 -> eight full warps (ids 0-7); overflow=1.
REQ-037 Second init.valid (workers=5) during SPAWN of a workers=64 launch -> exactly two full warps are emitted; overflow=1.
REQ-038 rst asserted after the first handshake of a workers=96 launch -> all outputs are 0 the next cycle; a new launch with workers=1 yields one warp, id 0, mask 0x00000001.

Source files
------------

// File: rtl/gelato_warp_spawner_pkg.sv
// Shared types for the warp spawner: launch geometry, descriptor fields and FSM states.
package gelato_types;

   localparam int unsigned WARP_SIZE = 32;
   localparam int unsigned NUM_WARPS = 8;
   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned WARP_ID_W = $clog2(NUM_WARPS);

   typedef logic [ADDR_W-1:0]    addr_t;
   typedef logic [WARP_ID_W-1:0] warp_id_t;
   typedef logic [WARP_SIZE-1:0] warp_mask_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SPAWN = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/gelato_warp_spawner_if.sv
// Launch request channel into the warp spawner.
interface gelato_init_if;
   import gelato_types::*;

   logic  valid;
   addr_t pc;
   int    workers;

   modport master (output valid, pc, workers);
   modport slave  (input  valid, pc, workers);
endinterface

// File: rtl/gelato_warp_spawner.sv
// Splits a launch of N worker threads into warp descriptors handed to the warp scheduler.
module gelato_warp_spawner #(
   parameter int unsigned WARP_SIZE = gelato_types::WARP_SIZE,
   parameter int unsigned NUM_WARPS = gelato_types::NUM_WARPS
) (
   input  logic                         clk,
   input  logic                         rst,
   gelato_init_if.slave                 init,
   output logic                         busy,
   output logic                         warp_valid,
   input  logic                         warp_ready,
   output logic [$clog2(NUM_WARPS)-1:0] warp_id,
   output gelato_types::addr_t          warp_pc,
   output logic [WARP_SIZE-1:0]         warp_mask,
   output logic                         done,
   output logic                         overflow
);
   import gelato_types::state_t;
   import gelato_types::IDLE;
   import gelato_types::SPAWN;
   import gelato_types::DONE;

   localparam int unsigned ID_W        = $clog2(NUM_WARPS);
   localparam int unsigned CNT_W       = $clog2(NUM_WARPS * WARP_SIZE) + 1;
   localparam int          MAX_WORKERS = int'(NUM_WARPS * WARP_SIZE);

   state_t           state;
   logic [CNT_W-1:0] remaining;
   logic [CNT_W-1:0] launch_cnt_c;
   logic [CNT_W-1:0] rem_next_c;
   logic             clamp_c;
   logic             hs_c;

   // Threads still to be spawned in the warp being presented: full warp or a low-bit tail.
   function automatic logic [WARP_SIZE-1:0] mask_of(input logic [CNT_W-1:0] rem);
      if (rem >= CNT_W'(WARP_SIZE)) return '1;
      return (WARP_SIZE'(1) << rem) - WARP_SIZE'(1);
   endfunction

   // workers is signed: zero or negative launches never reach the count register.
   always_comb begin
      clamp_c      = init.workers > MAX_WORKERS;
      launch_cnt_c = clamp_c ? CNT_W'(MAX_WORKERS) : CNT_W'(init.workers);
      hs_c         = warp_valid && warp_ready;
      rem_next_c   = (remaining > CNT_W'(WARP_SIZE)) ? remaining - CNT_W'(WARP_SIZE) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         remaining  <= '0;
         busy       <= 1'b0;
         warp_valid <= 1'b0;
         warp_id    <= '0;
         warp_pc    <= '0;
         warp_mask  <= '0;
         done       <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         done <= 1'b0;
         // A request that cannot be served is dropped but remembered.
         if (init.valid && (state != IDLE)) overflow <= 1'b1;

         case (state)
            IDLE: begin
               if (init.valid) begin
                  busy <= 1'b1;
                  if (init.workers > 0) begin
                     state      <= SPAWN;
                     remaining  <= launch_cnt_c;
                     warp_valid <= 1'b1;
                     warp_id    <= '0;
                     warp_pc    <= init.pc;
                     warp_mask  <= mask_of(launch_cnt_c);
                     if (clamp_c) overflow <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            SPAWN: begin
               if (hs_c) begin
                  remaining <= rem_next_c;
                  warp_id   <= warp_id + ID_W'(1);
                  if (rem_next_c == '0) begin
                     state      <= DONE;
                     warp_valid <= 1'b0;
                     done       <= 1'b1;
                  end else begin
                     warp_mask <= mask_of(rem_next_c);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               busy       <= 1'b0;
               warp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gelato_warp_spawner.sv
// Directed and randomized launches checked against a per-launch list of expected warps.
module tb_gelato_warp_spawner;

   localparam int WS   = 32;
   localparam int NW   = 8;
   localparam int MAXW = WS * NW;

   logic        clk = 1'b0;
   logic        rst;
   logic        busy, warp_valid, warp_ready, done, overflow;
   logic [2:0]  warp_id;
   logic [31:0] warp_pc;
   logic [31:0] warp_mask;

   int vectors     = 0;
   int miscompares = 0;
   bit exp_ovf     = 1'b0;

   gelato_init_if init_bus ();

   gelato_warp_spawner #(.WARP_SIZE(WS), .NUM_WARPS(NW)) dut (
      .clk        (clk),
      .rst        (rst),
      .init       (init_bus),
      .busy       (busy),
      .warp_valid (warp_valid),
      .warp_ready (warp_ready),
      .warp_id    (warp_id),
      .warp_pc    (warp_pc),
      .warp_mask  (warp_mask),
      .done       (done),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, ".valid"}, 64'(warp_valid), 64'd0);
      chk({tag, ".busy"},  64'(busy),       64'd0);
      chk({tag, ".done"},  64'(done),       64'd0);
      chk({tag, ".ovf"},   64'(overflow),   64'd0);
      chk({tag, ".id"},    64'(warp_id),    64'd0);
      chk({tag, ".pc"},    64'(warp_pc),    64'd0);
      chk({tag, ".mask"},  64'(warp_mask),  64'd0);
   endtask

   // Presents one launch at a negedge and follows it until the FSM is back in IDLE.
   task automatic run_launch(input logic [31:0] pc, input int workers, input int ready_pct,
                             input int stall, input int intrude_at, input string tag);
      int          n, nw, k, it, left;
      logic [63:0] em;
      n  = (workers <= 0) ? 0 : ((workers > MAXW) ? MAXW : workers);
      if (workers > MAXW) exp_ovf = 1'b1;
      nw = (n + WS - 1) / WS;
      init_bus.valid   = 1'b1;
      init_bus.pc      = pc;
      init_bus.workers = workers;
      @(negedge clk);
      init_bus.valid = 1'b0;
      k  = 0;
      it = 0;
      while (k < nw && it < 400) begin
         left = n - WS * k;
         em   = (left >= WS) ? 64'hFFFF_FFFF : ((64'd1 << left) - 64'd1);
         chk({tag, ".valid"}, 64'(warp_valid), 64'd1);
         chk({tag, ".busy"},  64'(busy),       64'd1);
         chk({tag, ".id"},    64'(warp_id),    64'(k));
         chk({tag, ".pc"},    64'(warp_pc),    64'(pc));
         chk({tag, ".mask"},  64'(warp_mask),  em);
         if (it == intrude_at) begin
            init_bus.valid   = 1'b1;
            init_bus.pc      = ~pc;
            init_bus.workers = 5;
            exp_ovf          = 1'b1;
         end else begin
            init_bus.valid = 1'b0;
         end
         warp_ready = (it >= stall) && ($urandom_range(99) < 32'(ready_pct));
         if (warp_ready) k++;
         it++;
         @(negedge clk);
      end
      init_bus.valid = 1'b0;
      if (k < nw) chk({tag, ".timeout"}, 64'(k), 64'(nw));
      chk({tag, ".end_valid"}, 64'(warp_valid), 64'd0);
      chk({tag, ".done"},      64'(done),       64'd1);
      chk({tag, ".done_busy"}, 64'(busy),       64'd1);
      @(negedge clk);
      chk({tag, ".done_clr"},  64'(done),       64'd0);
      chk({tag, ".idle_busy"}, 64'(busy),       64'd0);
      chk({tag, ".idle_vld"},  64'(warp_valid), 64'd0);
      chk({tag, ".ovf"},       64'(overflow),   64'(exp_ovf));
   endtask

   initial begin
      rst              = 1'b1;
      warp_ready       = 1'b0;
      init_bus.valid   = 1'b0;
      init_bus.pc      = '0;
      init_bus.workers = 0;
      repeat (2) @(negedge clk);
      chk_idle_zero("reset");
      rst = 1'b0;

      run_launch(32'h0000_2000,   0, 100, 0, -1, "zero");
      run_launch(32'h0000_2004,  -5, 100, 0, -1, "neg");
      run_launch(32'h0000_1000,  70, 100, 0, -1, "w70");
      run_launch(32'h0000_3000,  32, 100, 5, -1, "stall");
      run_launch(32'h0000_4000, 300, 100, 0, -1, "clamp");
      run_launch(32'h0000_5000,  64, 100, 0,  0, "intrude");

      // Reset in the middle of a 96-thread launch, then a single-thread launch.
      init_bus.valid   = 1'b1;
      init_bus.pc      = 32'h0000_6000;
      init_bus.workers = 96;
      @(negedge clk);
      init_bus.valid = 1'b0;
      chk("rst96.valid0", 64'(warp_valid), 64'd1);
      warp_ready = 1'b1;
      @(negedge clk);
      chk("rst96.id1", 64'(warp_id), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_idle_zero("rst96.after");
      rst     = 1'b0;
      exp_ovf = 1'b0;
      run_launch(32'h0000_7000, 1, 100, 0, -1, "one");

      for (int i = 0; i < 24; i++) begin
         int wk, pct, intr;
         wk   = int'($urandom_range(330)) - 10;
         pct  = int'($urandom_range(100, 30));
         intr = ($urandom_range(3) == 0) ? int'($urandom_range(6)) : -1;
         run_launch($urandom(), wk, pct, int'($urandom_range(2)), intr, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
